// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S output path (also used by sample_processor).
// Contents:
//   size_e        - sample size codes carried alongside each sample
//   SAMPLE_W etc. - widths of a FIFO entry {sample, size_code}
//   size_bits()   - size code -> number of valid sample bits
//   left_justify()- move the low N bits of a sample to the top of a 32-bit slot
package i2s_pkg;

   typedef enum logic [2:0] {
      S_8BIT  = 3'd0,
      S_12BIT = 3'd1,
      S_16BIT = 3'd3,
      S_32BIT = 3'd4
   } size_e;

   localparam int SAMPLE_W = 32;
   localparam int SIZE_W   = 3;
   localparam int FIFO_W   = SAMPLE_W + SIZE_W;

   // Unlisted codes fall back to 16 bits.
   function automatic logic [5:0] size_bits(input logic [2:0] code);
      logic [5:0] n;
      case (code)
         S_8BIT:  n = 6'd8;
         S_12BIT: n = 6'd12;
         S_32BIT: n = 6'd32;
         default: n = 6'd16;
      endcase
      return n;
   endfunction

   // Shifting left by (32-N) discards the unused upper bits and zero-fills the tail.
   function automatic logic [31:0] left_justify(input logic [31:0] sample,
                                                input logic [2:0]  code);
      logic [5:0] n;
      n = size_bits(code);
      return sample << (6'd32 - n);
   endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous sample FIFO with show-ahead read data and occupancy level.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_push    - write request (accepted only while o_ready is high)
//   i_data    - entry to write {sample, size_code}
//   i_pop     - read request (ignored while empty)
//   o_data    - head entry, valid while !o_empty
//   o_empty   - no entries stored
//   o_ready   - registered not-full flag
//   o_level   - number of stored entries
module i2s_sample_fifo
   import i2s_pkg::*;
#(
   parameter int WIDTH = FIFO_W,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_empty,
   output logic                       o_ready,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             r_ready;
   logic             w_push;
   logic             w_pop;
   logic [LW-1:0]    w_level_nxt;

   // A push is gated by the registered ready, so a pop in the same cycle
   // cannot open room for a push that arrives while full.
   assign w_push = i_push && r_ready;
   assign w_pop  = i_pop && (r_level != '0);

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + LW'(1);
      end else if (!w_push && w_pop) begin
         w_level_nxt = r_level - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_ready  <= 1'b1;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level <= w_level_nxt;
         r_ready <= (w_level_nxt != LW'(DEPTH));
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_empty = (r_level == '0);
   assign o_ready = r_ready;
   assign o_level = r_level;

endmodule

// File: rtl/i2s_serializer.sv
// I2S transmitter: buffers right-justified samples in a FIFO and streams them
// as left-justified 32-bit slots (one-bit I2S delay, left channel = lrclk low).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   enable                    - run the bit clock / frame; low holds outputs at 0
//   sample_in, sample_size    - sample and its size code, pushed when
//   sample_valid/sample_ready   sample_valid && sample_ready
//   bclk, lrclk, sdata        - I2S bit clock, word select, serial data
//   fifo_level                - FIFO occupancy
//   underrun                  - one-cycle pulse when a slot found the FIFO empty
//   underrun_count            - saturating underrun counter, present only when
//                               I2S_UNDERRUN_CNT_EN is defined
// Handshake: an entry is accepted on a rising clk edge where sample_valid and
// sample_ready are both high; sample_ready is a register equal to !full.
module i2s_serializer
   import i2s_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [31:0]                   sample_in,
   input  logic [2:0]                    sample_size,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   output logic                          bclk,
   output logic                          lrclk,
   output logic                          sdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun
`ifdef I2S_UNDERRUN_CNT_EN
   ,
   output logic [15:0]                   underrun_count
`endif
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0]  r_div;
   logic [5:0]        r_fc;
   logic              r_bclk;
   logic              r_lrclk;
   logic              r_sdata;
   logic              r_underrun;
   logic [31:0]       r_shift;

   logic              w_wrap;
   logic              w_fall;
   logic [5:0]        w_fc_nxt;
   logic              w_pop_slot;
   logic              w_fifo_empty;
   logic [FIFO_W-1:0] w_fifo_data;
   logic [31:0]       w_just;

   assign w_wrap     = (r_div == DIV_LAST);
   // bclk falls when the divider wraps while bclk is high.
   assign w_fall     = enable && w_wrap && r_bclk;
   assign w_fc_nxt   = r_fc + 6'd1;
   // Slots start one bit after lrclk changes (fc 0 -> 1, 32 -> 33).
   assign w_pop_slot = w_fall && ((w_fc_nxt == 6'd1) || (w_fc_nxt == 6'd33));
   assign w_just     = left_justify(w_fifo_data[FIFO_W-1:SIZE_W],
                                    w_fifo_data[SIZE_W-1:0]);

   i2s_sample_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (sample_valid),
      .i_data  ({sample_in, sample_size}),
      .i_pop   (w_pop_slot),
      .o_data  (w_fifo_data),
      .o_empty (w_fifo_empty),
      .o_ready (sample_ready),
      .o_level (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         r_div      <= '0;
         r_fc       <= '0;
         r_bclk     <= 1'b0;
         r_lrclk    <= 1'b0;
         r_sdata    <= 1'b0;
         r_underrun <= 1'b0;
         r_shift    <= '0;
      end else begin
         r_underrun <= 1'b0;
         r_div      <= w_wrap ? '0 : r_div + DIV_W'(1);
         if (w_wrap) begin
            r_bclk <= !r_bclk;
         end
         if (w_fall) begin
            r_fc    <= w_fc_nxt;
            r_lrclk <= w_fc_nxt[5];
            if (w_pop_slot) begin
               // An empty FIFO turns the whole slot into zeros; the next slot
               // still belongs to the other channel.
               if (w_fifo_empty) begin
                  r_shift    <= '0;
                  r_sdata    <= 1'b0;
                  r_underrun <= 1'b1;
               end else begin
                  r_shift <= w_just;
                  r_sdata <= w_just[31];
               end
            end else begin
               // r_shift[31] is the bit currently on sdata.
               r_shift <= {r_shift[30:0], 1'b0};
               r_sdata <= r_shift[30];
            end
         end
      end
   end

   assign bclk     = r_bclk;
   assign lrclk    = r_lrclk;
   assign sdata    = r_sdata;
   assign underrun = r_underrun;

`ifdef I2S_UNDERRUN_CNT_EN
   logic [15:0] r_underrun_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_underrun_count <= '0;
      end else if (w_pop_slot && w_fifo_empty && (r_underrun_count != 16'hFFFF)) begin
         r_underrun_count <= r_underrun_count + 16'd1;
      end
   end

   assign underrun_count = r_underrun_count;
`endif

endmodule

// File: tb/tb_i2s_serializer.sv
// Bench for i2s_serializer (CLK_DIV=2, FIFO_DEPTH=4). A reference model derives
// every output from the count of enabled clk edges and a sample queue; it is
// compared with the DUT each cycle. Directed tests decode the serial stream at
// bclk rises and compare slots with hand-computed words.
module tb_i2s_serializer;

   localparam int CLK_DIV    = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic [31:0]      sample_in;
   logic [2:0]       sample_size;
   logic             sample_valid;
   wire              sample_ready;
   wire              bclk;
   wire              lrclk;
   wire              sdata;
   wire [LVL_W-1:0]  fifo_level;
   wire              underrun;
`ifdef I2S_UNDERRUN_CNT_EN
   wire [15:0]       underrun_count;
`endif

   always #5 clk = ~clk;

   i2s_serializer #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .sample_in      (sample_in),
      .sample_size    (sample_size),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .bclk           (bclk),
      .lrclk          (lrclk),
      .sdata          (sdata),
      .fifo_level     (fifo_level),
      .underrun       (underrun)
`ifdef I2S_UNDERRUN_CNT_EN
      ,
      .underrun_count (underrun_count)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- reference model ----------------
   logic [34:0] m_q[$];
   int          m_n;
   int          m_fc = 0;
   logic [31:0] m_word;
   logic        m_bclk, m_lrclk, m_sdata, m_underrun;
   logic        m_ready;
   logic        m_valid = 1'b0;
   logic [15:0] m_ucnt;

   // receiver capture
   logic        rx_sd[$];
   logic        rx_lr[$];
   int          rx_t[$];
   logic        rx_prev = 1'b0;
   int          ur_seen = 0;
   int          cyc = 0;

   function automatic logic [31:0] ref_justify(input logic [31:0] s, input logic [2:0] code);
      int nb;
      logic [31:0] mask;
      case (code)
         3'd0:    nb = 8;
         3'd1:    nb = 12;
         3'd4:    nb = 32;
         default: nb = 16;
      endcase
      if (nb == 32) return s;
      mask = (32'd1 << nb) - 32'd1;
      return (s & mask) << (32 - nb);
   endfunction

   always @(posedge clk) begin : model_p
      logic do_push;
      int   h;
      cyc++;
      if (rst) begin
         m_q.delete();
         m_n = 0; m_fc = 0; m_word = '0;
         m_bclk = 1'b0; m_lrclk = 1'b0; m_sdata = 1'b0; m_underrun = 1'b0;
         m_ready = 1'b1; m_ucnt = '0; m_valid = 1'b1;
      end else if (m_valid) begin
         do_push = sample_valid && m_ready;
         m_underrun = 1'b0;
         if (!enable) begin
            m_n = 0; m_fc = 0;
            m_bclk = 1'b0; m_lrclk = 1'b0; m_sdata = 1'b0;
         end else begin
            m_n++;
            h = m_n / CLK_DIV;
            m_bclk = (h % 2) != 0;
            // Falling bclk: end of an even-numbered half period.
            if ((m_n % CLK_DIV) == 0 && (h % 2) == 0) begin
               m_fc = (h / 2) % 64;
               m_lrclk = (m_fc >= 32);
               if (m_fc == 1 || m_fc == 33) begin
                  if (m_q.size() > 0) begin
                     m_word = ref_justify(m_q[0][34:3], m_q[0][2:0]);
                     void'(m_q.pop_front());
                  end else begin
                     m_word = '0;
                     m_underrun = 1'b1;
                     if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
                  end
               end
               m_sdata = m_word[31 - ((m_fc + 63) % 32)];
            end
         end
         if (do_push) m_q.push_back({sample_in, sample_size});
         m_ready = (m_q.size() < FIFO_DEPTH);
      end

      #1;
      if (m_valid) begin
         n_cmp++;
         if ({bclk, lrclk, sdata, underrun, sample_ready} !== {m_bclk, m_lrclk, m_sdata, m_underrun, m_ready}
             || fifo_level !== LVL_W'(m_q.size())) begin
            n_err++;
            $display("FAIL cycle_model cyc=%0d bclk/lr/sd/ur/rdy got %b%b%b%b%b lvl %0d, expected %b%b%b%b%b lvl %0d",
                     cyc, bclk, lrclk, sdata, underrun, sample_ready, fifo_level,
                     m_bclk, m_lrclk, m_sdata, m_underrun, m_ready, m_q.size());
         end
`ifdef I2S_UNDERRUN_CNT_EN
         n_cmp++;
         if (underrun_count !== m_ucnt) begin
            n_err++;
            $display("FAIL cycle_ucnt cyc=%0d got %0d, expected %0d", cyc, underrun_count, m_ucnt);
         end
`endif
         if (bclk === 1'b1 && rx_prev === 1'b0) begin
            rx_sd.push_back(sdata);
            rx_lr.push_back(lrclk);
            rx_t.push_back(cyc);
         end
         if (underrun === 1'b1) ur_seen++;
      end
      rx_prev = bclk;
   end

   // ---------------- helpers ----------------
   task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rx_word(input int base);
      logic [31:0] w;
      w = 'x;
      if (base + 31 < rx_sd.size()) begin
         for (int i = 0; i < 32; i++) w = {w[30:0], rx_sd[base + i]};
      end
      return w;
   endfunction

   task automatic start_capture();
      rx_sd.delete();
      rx_lr.delete();
      rx_t.delete();
      ur_seen = 0;
   endtask

   task automatic push(input logic [31:0] s, input logic [2:0] c);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = s;
      sample_size  = c;
   endtask

   task automatic idle();
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_rises(input int k);
      int budget;
      budget = 0;
      while (rx_sd.size() < k && budget < 4000) begin
         @(negedge clk);
         budget++;
      end
      if (rx_sd.size() < k) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_rises: got %0d rises, expected %0d", rx_sd.size(), k);
      end
   endtask

   // Enables output, collects k bclk rises, and disables before the next slot pop.
   task automatic run_rises(input int k);
      @(negedge clk);
      start_capture();
      enable = 1'b1;
      wait_rises(k);
      enable = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin : stim
      logic any_one;
      int   budget;
      rst = 1'b1; enable = 1'b0; sample_valid = 1'b0;
      sample_in = '0; sample_size = '0;
      repeat (3) @(negedge clk);
      check_b("rst_bclk", bclk, 1'b0);
      check_b("rst_lrclk", lrclk, 1'b0);
      check_b("rst_sdata", sdata, 1'b0);
      check_b("rst_ready", sample_ready, 1'b1);
      check_w("rst_level", 32'(fifo_level), 32'd0);
      rst = 1'b0;

      // Empty FIFO: zeros, two underruns per frame.
      run_rises(129);
      any_one = 1'b0;
      foreach (rx_sd[i]) any_one |= rx_sd[i];
      check_b("empty_sdata_zero", any_one, 1'b0);
      check_w("empty_underruns", 32'(ur_seen), 32'd4);
`ifdef I2S_UNDERRUN_CNT_EN
      check_w("empty_underrun_count", 32'(underrun_count), 32'd4);
`endif
      @(negedge clk);

      // 12-bit samples, bclk period and slot alignment.
      push(32'h0000_0ABC, 3'd1);
      push(32'h0000_0123, 3'd1);
      idle();
      run_rises(65);
      check_w("s12_bclk_period", 32'(rx_t[1] - rx_t[0]), 32'd4);
      check_b("s12_lr_fc0", rx_lr[0], 1'b0);
      check_b("s12_sd_fc0", rx_sd[0], 1'b0);
      check_w("s12_left", rx_word(1), 32'hABC0_0000);
      check_w("s12_right", rx_word(33), 32'h1230_0000);
      @(negedge clk);

      // 32-bit alternating patterns and lrclk toggle points.
      push(32'hAAAA_AAAA, 3'd4);
      push(32'h5555_5555, 3'd4);
      idle();
      run_rises(65);
      check_w("s32_left", rx_word(1), 32'hAAAA_AAAA);
      check_w("s32_right", rx_word(33), 32'h5555_5555);
      check_b("s32_lr_fc31", rx_lr[31], 1'b0);
      check_b("s32_lr_fc32", rx_lr[32], 1'b1);
      check_b("s32_lr_fc63", rx_lr[63], 1'b1);
      check_b("s32_lr_fc0_next", rx_lr[64], 1'b0);
      @(negedge clk);

      // 8-bit and unknown size code (treated as 16 bits).
      push(32'h0000_00FF, 3'd0);
      push(32'h0000_F00F, 3'd7);
      idle();
      run_rises(65);
      check_w("s8_left", rx_word(1), 32'hFF00_0000);
      check_w("code7_right", rx_word(33), 32'hF00F_0000);
      @(negedge clk);

      // Fill while disabled: fifth push is dropped.
      push(32'h0000_1111, 3'd3);
      push(32'h0000_2222, 3'd3);
      push(32'h0000_3333, 3'd3);
      push(32'h0000_4444, 3'd3);
      push(32'h0000_5555, 3'd3);
      check_b("full_ready", sample_ready, 1'b0);
      check_w("full_level", 32'(fifo_level), 32'd4);
      idle();
      check_w("full_level_after5", 32'(fifo_level), 32'd4);
      run_rises(161);
      check_w("full_w0", rx_word(1), 32'h1111_0000);
      check_w("full_w1", rx_word(33), 32'h2222_0000);
      check_w("full_w2", rx_word(65), 32'h3333_0000);
      check_w("full_w3", rx_word(97), 32'h4444_0000);
      check_w("full_w4_dropped", rx_word(129), 32'h0000_0000);
      check_w("full_underruns", 32'(ur_seen), 32'd1);
      @(negedge clk);

      // Reset mid-frame at fc=40 with a sample still queued.
      push(32'h0000_BEEF, 3'd3);
      push(32'h0000_CAFE, 3'd3);
      push(32'h0000_9999, 3'd3);
      idle();
      @(negedge clk);
      start_capture();
      enable = 1'b1;
      budget = 0;
      while (m_fc != 40 && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      if (m_fc != 40) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_fc40: got fc %0d, expected 40", m_fc);
      end
      check_w("mid_level_before_rst", 32'(fifo_level), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_b("midrst_bclk", bclk, 1'b0);
      check_b("midrst_lrclk", lrclk, 1'b0);
      check_b("midrst_sdata", sdata, 1'b0);
      check_b("midrst_underrun", underrun, 1'b0);
      check_b("midrst_ready", sample_ready, 1'b1);
      check_w("midrst_level", 32'(fifo_level), 32'd0);
      rst = 1'b0;
      start_capture();
      sample_valid = 1'b1;
      sample_in    = 32'h0000_1234;
      sample_size  = 3'd3;
      push(32'h0000_5678, 3'd3);
      idle();
      wait_rises(65);
      enable = 1'b0;
      check_b("post_rst_lr_fc0", rx_lr[0], 1'b0);
      check_b("post_rst_lr_fc32", rx_lr[32], 1'b1);
      check_w("post_rst_left", rx_word(1), 32'h1234_0000);
      check_w("post_rst_right", rx_word(33), 32'h5678_0000);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/i2s_serializer.md
I2S_SERIALIZER -- requirements
Module: i2s_serializer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per bclk half-period, legal values >= 1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: sample FIFO entries, power of two, >= 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: starts or stops the I2S output.
REQ-006 SHALL have port sample_in, input, 32: right-justified sample from sample_processor data_out.
REQ-007 SHALL have port sample_size, input, 3: size code 0=8, 1=12, 3=16, 4=32 bits; other codes mean 16 bits.
REQ-008 SHALL have port sample_valid, input, 1: a sample is offered (sample_processor data_ready).
REQ-009 SHALL have port sample_ready, output, 1: the FIFO is not full.
REQ-010 SHALL have ports bclk, lrclk and sdata, outputs, 1 each: the I2S bit clock, word select and serial data.
REQ-011 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.
REQ-012 SHALL have port underrun, output, 1: one-cycle pulse when a pop finds the FIFO empty.

Function
REQ-013 SHALL push {sample_in, sample_size} into the FIFO when sample_valid && sample_ready; sample_ready SHALL be registered and equal to !full.
REQ-014 SHALL ignore sample_valid while full, even if a pop occurs in the same cycle.
REQ-015 SHALL leave fifo_level unchanged on a simultaneous push and pop.
REQ-016 SHALL treat a pop with an empty FIFO and a same-cycle push as an underrun; there is no bypass path.
REQ-017 SHALL run a divider div_cnt from 0 to CLK_DIV-1 and toggle bclk on each wrap, giving a bclk period of 2*CLK_DIV clk cycles.
REQ-018 SHALL update lrclk and sdata only on bclk falling transitions.
REQ-019 SHALL advance a frame counter fc (0..63) by one on each bclk falling transition.
REQ-020 SHALL drive lrclk low for fc 0..31 and high for fc 32..63 (left channel = low).
REQ-021 SHALL pop the left sample at the transition to fc=1 and the right sample at fc=33, giving a one-bit I2S delay after lrclk changes.
REQ-022 SHALL left-justify each popped sample into a 32-bit shifter, taking its low N bits with N from the stored size code and zero-filling the remainder.
REQ-023 SHALL drive sdata with the shifter MSB at the pop edge and shift left by one on each following falling edge.
REQ-024 SHALL transmit a full slot of all zeros on an underrun and pulse underrun for one clk.
REQ-025 SHALL keep channel alternation after an underrun: the next pop is for the opposite channel.
REQ-026 SHALL hold bclk, lrclk and sdata low and hold div_cnt and fc at 0 while enable=0; the FIFO SHALL still accept pushes.
REQ-027 SHALL start the frame at fc=0 with the first bclk rise CLK_DIV cycles after enable rises.
REQ-028 SHALL clear enabled output immediately on enable fall, abandoning any partial frame without popping.

Reset
REQ-029 SHALL, on rst high at a clk edge, make the following hold in the next cycle: bclk=0, lrclk=0, sdata=0, underrun=0, fifo_level=0, sample_ready=1, div_cnt=0, fc=0, shifter=0, FIFO pointers=0.
REQ-030 SHALL apply reset mid-frame identically, discarding all FIFO contents.

Configuration
REQ-031 SHALL, with I2S_UNDERRUN_CNT_EN defined, add output underrun_count, 16 bits, incremented on each underrun pulse, saturating at 0xFFFF and cleared by rst.
REQ-032 SHALL, without I2S_UNDERRUN_CNT_EN, omit the underrun_count port and its counter entirely.

Structure
REQ-033 SHALL place the size codes (S_8BIT=0, S_12BIT=1, S_16BIT=3, S_32BIT=4) and a size-to-bit-count function in the shared package i2s_pkg, which sample_processor also uses.
REQ-034 SHALL implement the FIFO as sub-module i2s_sample_fifo (synchronous, width 35, depth FIFO_DEPTH, with level output); bit-clock and frame logic SHALL stay in i2s_serializer.

Verification
REQ-035 SHALL cover: CLK_DIV=2, push L=0x00000ABC (12-bit) and R=0x00000123 (12-bit), enable -> bclk period 4 clk; left slot sdata=1010_1011_1100 then 20 zeros, MSB one bclk after lrclk falls; right slot 0001_0010_0011 then 20 zeros.
REQ-036 SHALL cover: 32-bit L=0xAAAAAAAA and R=0x55555555 -> alternating bits, with lrclk toggling exactly at fc 0 and 32.
REQ-037 SHALL cover: 8-bit 0x000000FF -> eight ones then 24 zeros; size code 7 with 0x0000F00F -> 1111000000001111 then 16 zeros.
REQ-038 SHALL cover: enable with an empty FIFO -> sdata constant 0, underrun pulsing twice per frame, and underrun_count=4 after two frames when I2S_UNDERRUN_CNT_EN is defined.
REQ-039 SHALL cover: FIFO_DEPTH=4, enable=0, five valid pushes -> sample_ready low after the fourth, fifo_level=4, fifth sample dropped (absent from the output once enabled).
REQ-040 SHALL cover: rst asserted at fc=40 -> next cycle all outputs 0, fifo_level=0, sample_ready=1; a new frame starts cleanly after rst is released.
